// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute
// redirect and the decode-side valid/ready handshake.
interface fetch_prefetch_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int OCCW = $clog2(DEPTH) + 1;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_data;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus4;
    logic [OCCW-1:0] occupancy;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr_data, instr_pc, instr_pc_plus4, occupancy,
        input  instr_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr_data, instr_pc, instr_pc_plus4, occupancy,
        output instr_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues in-order requests to a variable-latency
// instruction memory, buffers PC/instruction pairs in a DEPTH-entry queue and
// hands them to decode. Redirects flush the queue and squash in-flight
// responses through a drop counter.
//
// Entry states:
//   state   | meaning
//   EMPTY   | slot free
//   PENDING | request accepted, response not yet received
//   FILLED  | instruction word written, waiting for decode
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              reset,
    fetch_prefetch_if.master bus
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        FILLED  = 2'd2
    } entryState_t;

    entryState_t     entryState     [DEPTH];
    entryState_t     entryStateNext [DEPTH];
    logic [XLEN-1:0] entryPc        [DEPTH];
    logic [XLEN-1:0] entryPcNext    [DEPTH];
    logic [31:0]     entryData      [DEPTH];
    logic [31:0]     entryDataNext  [DEPTH];

    // fillPtr tracks the oldest PENDING entry; pending entries always sit
    // contiguously between fillPtr and tailPtr because responses are in order.
    logic [PTRW-1:0] headPtr, headPtrNext;
    logic [PTRW-1:0] tailPtr, tailPtrNext;
    logic [PTRW-1:0] fillPtr, fillPtrNext;
    logic [CNTW-1:0] occ, occNext;
    logic [CNTW-1:0] pendCnt, pendCntNext;
    logic [CNTW-1:0] dropCnt, dropCntNext;
    logic [XLEN-1:0] fetchPc, fetchPcNext;

    logic            reqValid;
    logic            accept;
    logic            instrValid;
    logic            dequeue;
    logic            respIn;
    logic            fill;
    logic [CNTW:0]   allocSum;
    logic [CNTW-1:0] squashed;

    // Handshake decisions for this cycle, all from registered state
    always_comb begin
        allocSum   = {1'b0, occ} + {1'b0, dropCnt};
        reqValid   = !reset && !bus.redirect_valid && (occ < DEPTH_C)
                     && (allocSum < {1'b0, DEPTH_C});
        accept     = reqValid && bus.imem_req_ready;
        instrValid = !reset && !bus.redirect_valid && (entryState[headPtr] == FILLED);
        dequeue    = instrValid && bus.instr_ready;
        respIn     = bus.imem_resp_valid && !reset;
        fill       = respIn && !bus.redirect_valid && (dropCnt == '0) && (pendCnt != '0);
    end

    // Next-state for the queue, pointers, counters and fetch PC
    always_comb begin
        entryStateNext = entryState;
        entryPcNext    = entryPc;
        entryDataNext  = entryData;
        headPtrNext    = headPtr;
        tailPtrNext    = tailPtr;
        fillPtrNext    = fillPtr;
        occNext        = occ;
        pendCntNext    = pendCnt;
        dropCntNext    = dropCnt;
        fetchPcNext    = fetchPc;
        squashed       = dropCnt + pendCnt;

        if (bus.redirect_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                entryStateNext[i] = EMPTY;
            end
            headPtrNext = '0;
            tailPtrNext = '0;
            fillPtrNext = '0;
            occNext     = '0;
            pendCntNext = '0;
            // A response landing in the redirect cycle retires one of the
            // outstanding requests (dropped or pending) on the spot.
            if (respIn && (squashed != '0)) begin
                dropCntNext = squashed - CNT_ONE;
            end else begin
                dropCntNext = squashed;
            end
            fetchPcNext = bus.redirect_pc & PC_ALIGN;
        end else begin
            if (accept) begin
                entryStateNext[tailPtr] = PENDING;
                entryPcNext[tailPtr]    = fetchPc;
                tailPtrNext             = tailPtr + PTR_ONE;
                fetchPcNext             = fetchPc + PC_STEP;
            end
            if (respIn && (dropCnt != '0)) begin
                dropCntNext = dropCnt - CNT_ONE;
            end
            if (fill) begin
                entryStateNext[fillPtr] = FILLED;
                entryDataNext[fillPtr]  = bus.imem_resp_data;
                fillPtrNext             = fillPtr + PTR_ONE;
            end
            if (dequeue) begin
                entryStateNext[headPtr] = EMPTY;
                headPtrNext             = headPtr + PTR_ONE;
            end
            case ({accept, dequeue})
                2'b10:   occNext = occ + CNT_ONE;
                2'b01:   occNext = occ - CNT_ONE;
                default: occNext = occ;
            endcase
            case ({accept, fill})
                2'b10:   pendCntNext = pendCnt + CNT_ONE;
                2'b01:   pendCntNext = pendCnt - CNT_ONE;
                default: pendCntNext = pendCnt;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entryState[i] <= EMPTY;
            end
            headPtr <= '0;
            tailPtr <= '0;
            fillPtr <= '0;
            occ     <= '0;
            pendCnt <= '0;
            dropCnt <= '0;
            fetchPc <= RESET_PC;
        end else begin
            entryState <= entryStateNext;
            headPtr    <= headPtrNext;
            tailPtr    <= tailPtrNext;
            fillPtr    <= fillPtrNext;
            occ        <= occNext;
            pendCnt    <= pendCntNext;
            dropCnt    <= dropCntNext;
            fetchPc    <= fetchPcNext;
        end
    end

    // Payload storage; only meaningful where the entry state says so
    always_ff @(posedge clk) begin
        entryPc   <= entryPcNext;
        entryData <= entryDataNext;
    end

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_req_addr  = fetchPc;
    assign bus.instr_valid    = instrValid;
    assign bus.instr_data     = entryData[headPtr];
    assign bus.instr_pc       = entryPc[headPtr];
    assign bus.instr_pc_plus4 = entryPc[headPtr] + PC_STEP;
    assign bus.occupancy      = reset ? '0 : occ;
endmodule
